// File: rtl/match_mon_pkg.sv
// match_monitor shared types and constants.
// Slot state and default sizing for the windowed match counter.
package match_mon_pkg;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_t;

  localparam int WINDOW_DEF  = 16;
  localparam int CNT_W_DEF   = 8;
  localparam int THRESH_DEF  = 3;
  localparam int HIT_TOTAL_W = 16;

endpackage

// File: rtl/match_monitor_win_timer.sv
// Enabled modulo-WINDOW timer.
// win_end flags the enabled cycle on which the window closes.
module win_timer #(
  parameter int WINDOW = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic win_end
);

  localparam int W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [W-1:0] LAST = W'(WINDOW - 1);

  logic [W-1:0] win_cnt;

  assign win_end = en && (win_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
    end else if (win_end) begin
      win_cnt <= '0;
    end else if (en) begin
      win_cnt <= win_cnt + W'(1);
    end
  end

endmodule

// File: rtl/match_monitor.sv
// Windowed match-event counter with a single-entry report slot.
// Reports carry count, threshold alarm and a dropped-report flag.
module match_monitor
  import match_mon_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   hit_i,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [CNT_W-1:0]       rpt_count,
  output logic                   rpt_alarm,
  output logic                   rpt_overrun,
  output logic [HIT_TOTAL_W-1:0] hit_total
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] TH   = CNT_W'(THRESH);

  logic             hit_q;
  logic             ev;
  logic             win_end;
  logic             accept;
  logic             ovf_pend;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] fin;
  slot_t            state;

  win_timer #(
    .WINDOW (WINDOW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .win_end (win_end)
  );

  assign ev     = hit_i & ~hit_q & en;
  assign fin    = (ev && cnt != CMAX) ? cnt + CNT_W'(1) : cnt;
  assign accept = (state == SLOT_FULL) & rpt_ready;

  assign rpt_valid = (state == SLOT_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q     <= 1'b0;
      cnt       <= '0;
      hit_total <= '0;
    end else begin
      hit_q     <= hit_i;
      hit_total <= hit_total + HIT_TOTAL_W'(ev);
      if (win_end) begin
        cnt <= '0;
      end else begin
        cnt <= fin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SLOT_EMPTY;
      ovf_pend    <= 1'b0;
      rpt_count   <= '0;
      rpt_alarm   <= 1'b0;
      rpt_overrun <= 1'b0;
    end else begin
      unique case (state)
        SLOT_EMPTY: begin
          if (win_end) begin
            state       <= SLOT_FULL;
            rpt_count   <= fin;
            rpt_alarm   <= (fin >= TH);
            rpt_overrun <= ovf_pend;
            ovf_pend    <= 1'b0;
          end
        end
        SLOT_FULL: begin
          // Accept on the window-end cycle frees room for the new report.
          if (win_end && accept) begin
            rpt_count   <= fin;
            rpt_alarm   <= (fin >= TH);
            rpt_overrun <= ovf_pend;
            ovf_pend    <= 1'b0;
          end else if (win_end) begin
            ovf_pend <= 1'b1;
          end else if (accept) begin
            state <= SLOT_EMPTY;
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_match_monitor.sv
// Self-checking bench for match_monitor.
// Vector table of single windows plus multi-cycle sequences.
module tb_match_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        hit_i = 1'b0;
  logic        rpt_ready = 1'b0;
  logic        rpt_valid;
  logic [7:0]  rpt_count;
  logic        rpt_alarm;
  logic        rpt_overrun;
  logic [15:0] hit_total;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [15:0] mask;
    int          count;
    int          alarm;
    int          total;
  } vec_t;

  vec_t vt [7];

  match_monitor #(
    .WINDOW (16),
    .CNT_W  (8),
    .THRESH (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .hit_i       (hit_i),
    .rpt_valid   (rpt_valid),
    .rpt_ready   (rpt_ready),
    .rpt_count   (rpt_count),
    .rpt_alarm   (rpt_alarm),
    .rpt_overrun (rpt_overrun),
    .hit_total   (hit_total)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    hit_i = 1'b0;
    rpt_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic run_window(input logic [15:0] mask, input logic rdy_last);
    for (int i = 0; i < 16; i++) begin
      en = 1'b1;
      hit_i = mask[i];
      rpt_ready = (i == 15) ? rdy_last : 1'b0;
      step();
    end
    en = 1'b0;
    hit_i = 1'b0;
    rpt_ready = 1'b0;
  endtask

  initial begin
    vt[0] = '{"idle",    16'h0000, 0, 0, 0};
    vt[1] = '{"pulse4",  16'h8224, 4, 1, 4};
    vt[2] = '{"held10",  16'h1FF8, 1, 0, 1};
    vt[3] = '{"alt8",    16'hAAAA, 8, 1, 8};
    vt[4] = '{"allhigh", 16'hFFFF, 1, 0, 1};
    vt[5] = '{"two",     16'h0110, 2, 0, 2};
    vt[6] = '{"three",   16'h0015, 3, 1, 3};

    do_reset();
    chk("rst_valid", rpt_valid, 0);
    chk("rst_count", rpt_count, 0);
    chk("rst_alarm", rpt_alarm, 0);
    chk("rst_ovr", rpt_overrun, 0);
    chk("rst_total", hit_total, 0);

    for (int k = 0; k < 7; k++) begin
      do_reset();
      for (int i = 0; i < 16; i++) begin
        en = 1'b1;
        hit_i = vt[k].mask[i];
        step();
        if (i == 14) chk({vt[k].name, "_early"}, rpt_valid, 0);
      end
      en = 1'b0;
      hit_i = 1'b0;
      chk({vt[k].name, "_valid"}, rpt_valid, 1);
      chk({vt[k].name, "_count"}, rpt_count, vt[k].count);
      chk({vt[k].name, "_alarm"}, rpt_alarm, vt[k].alarm);
      chk({vt[k].name, "_ovr"}, rpt_overrun, 0);
      chk({vt[k].name, "_total"}, hit_total, vt[k].total);
    end

    // Three windows unaccepted: first stays, next two drop.
    do_reset();
    run_window(16'h0008, 1'b0);
    chk("ovf_w1_count", rpt_count, 1);
    run_window(16'h0044, 1'b0);
    chk("ovf_w2_hold", rpt_count, 1);
    chk("ovf_w2_valid", rpt_valid, 1);
    run_window(16'h0444, 1'b0);
    chk("ovf_w3_hold", rpt_count, 1);
    chk("ovf_w3_ovr", rpt_overrun, 0);
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    chk("ovf_accept", rpt_valid, 0);
    run_window(16'h02AA, 1'b0);
    chk("ovf_w4_valid", rpt_valid, 1);
    chk("ovf_w4_count", rpt_count, 5);
    chk("ovf_w4_ovr", rpt_overrun, 1);
    chk("ovf_total", hit_total, 11);
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    run_window(16'h0000, 1'b0);
    chk("ovf_w5_count", rpt_count, 0);
    chk("ovf_w5_ovr", rpt_overrun, 0);

    // Accept coinciding with window end.
    do_reset();
    run_window(16'h0008, 1'b0);
    run_window(16'h0044, 1'b1);
    chk("same_valid", rpt_valid, 1);
    chk("same_count", rpt_count, 2);
    chk("same_ovr", rpt_overrun, 0);

    // Ready while empty has no effect; pause mid-window.
    do_reset();
    rpt_ready = 1'b1;
    step();
    step();
    rpt_ready = 1'b0;
    chk("rdy_empty", rpt_valid, 0);
    for (int i = 0; i < 8; i++) begin
      en = 1'b1;
      hit_i = (i == 2);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      en = 1'b0;
      hit_i = (i == 0 || i == 2);
      step();
    end
    chk("pause_total", hit_total, 1);
    for (int i = 0; i < 8; i++) begin
      en = 1'b1;
      hit_i = (i == 4);
      step();
      if (i == 6) chk("pause_early", rpt_valid, 0);
    end
    en = 1'b0;
    hit_i = 1'b0;
    chk("pause_valid", rpt_valid, 1);
    chk("pause_count", rpt_count, 2);
    chk("pause_total2", hit_total, 2);

    // Reset with a full slot clears all outputs.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rfull_valid", rpt_valid, 0);
    chk("rfull_count", rpt_count, 0);
    chk("rfull_total", hit_total, 0);
    run_window(16'h0000, 1'b0);
    chk("rfull_ovr", rpt_overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
